// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, widths and arbiter state encoding
package sdram_pkg;

  localparam int CMD_W = 18;

  // Opcode nibble is {cs_n, ras_n, cas_n, we_n}; it sits in bits [17:14] of a command.
  localparam logic [3:0] OP_NOP = 4'b0111;
  localparam logic [3:0] OP_PRE = 4'b0010;
  localparam logic [3:0] OP_REF = 4'b0001;
  localparam logic [3:0] OP_ACT = 4'b0011;
  localparam logic [3:0] OP_WR  = 4'b0100;
  localparam logic [3:0] OP_RD  = 4'b0101;
  localparam logic [3:0] OP_MRS = 4'b0000;

  localparam logic [CMD_W-1:0] NOP_CMD = 18'h1c000;
  localparam logic [CMD_W-1:0] PRE_CMD = {OP_PRE, 14'h0};
  localparam logic [CMD_W-1:0] REF_CMD = {OP_REF, 14'h0};
  localparam logic [CMD_W-1:0] ACT_CMD = {OP_ACT, 14'h0};
  localparam logic [CMD_W-1:0] WR_CMD  = {OP_WR, 14'h0};
  localparam logic [CMD_W-1:0] RD_CMD  = {OP_RD, 14'h0};
  localparam logic [CMD_W-1:0] MRS_CMD = {OP_MRS, 14'h0};

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [3:0] op,
                                                input logic [1:0] ba,
                                                input logic [11:0] addr);
    return {op, ba, addr};
  endfunction

endpackage

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter: init/refresh/write/read grant FSM, command mux and pin register
// Optional feature: RW_ROUND_ROBIN_EN alternates write/read grants when both are pending.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int GRANT_TMO = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] ini_cmd,
  input  logic             ini_end,
  input  logic             ref_req,
  input  logic [CMD_W-1:0] ref_cmd,
  input  logic             ref_end,
  output logic             ref_en,
  input  logic             wr_req,
  input  logic [CMD_W-1:0] wr_cmd,
  input  logic             wr_end,
  output logic             wr_en,
  input  logic             rd_req,
  input  logic [CMD_W-1:0] rd_cmd,
  input  logic             rd_end,
  output logic             rd_en,
  output logic             sdram_cke,
  output logic             sdram_cs_n,
  output logic             sdram_ras_n,
  output logic             sdram_cas_n,
  output logic             sdram_we_n,
  output logic [1:0]       sdram_ba,
  output logic [11:0]      sdram_addr,
  output logic             tmo_err
);

  localparam int CNT_W = $clog2(GRANT_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(GRANT_TMO);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] grant_cnt;
  logic [CMD_W-1:0] mux_cmd;
  logic [CMD_W-1:0] pin_cmd;
  logic             in_grant;
  logic             grant_end;
  logic             tmo_hit;
  logic             rw_pick_wr;

`ifdef RW_ROUND_ROBIN_EN
  // 1 = read was served last, so write wins the next write/read tie.
  logic last_rw_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rw_rd <= 1'b1;
    end else if (state == S_ARBIT && state_nxt == S_WRITE) begin
      last_rw_rd <= 1'b0;
    end else if (state == S_ARBIT && state_nxt == S_READ) begin
      last_rw_rd <= 1'b1;
    end
  end

  assign rw_pick_wr = last_rw_rd;
`else
  assign rw_pick_wr = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  assign in_grant = (state == S_AREF) || (state == S_WRITE) || (state == S_READ);

  always_comb begin
    state_nxt = state;
    mux_cmd   = NOP_CMD;
    grant_end = 1'b0;
    case (state)
      S_INIT: begin
        mux_cmd = ini_cmd;
        if (ini_end) state_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        if (ref_req)                state_nxt = S_AREF;
        else if (wr_req && rd_req)  state_nxt = rw_pick_wr ? S_WRITE : S_READ;
        else if (wr_req)            state_nxt = S_WRITE;
        else if (rd_req)            state_nxt = S_READ;
      end
      S_AREF: begin
        mux_cmd   = ref_cmd;
        grant_end = ref_end;
      end
      S_WRITE: begin
        mux_cmd   = wr_cmd;
        grant_end = wr_end;
      end
      S_READ: begin
        mux_cmd   = rd_cmd;
        grant_end = rd_end;
      end
      default: state_nxt = S_INIT;
    endcase
    // Only the owner's end pulse or the timeout releases the bus.
    if (in_grant && (grant_end || tmo_hit)) state_nxt = S_ARBIT;
  end

  assign tmo_hit = in_grant && !grant_end && (grant_cnt == TMO_VAL);

  // Held at zero outside grants, so it reads 0 on the first grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (!in_grant) begin
      grant_cnt <= '0;
    end else begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_err   <= 1'b0;
      pin_cmd   <= NOP_CMD;
      sdram_cke <= 1'b0;
    end else begin
      tmo_err   <= tmo_err | tmo_hit;
      pin_cmd   <= mux_cmd;
      sdram_cke <= 1'b1;
    end
  end

  assign ref_en = (state == S_AREF);
  assign wr_en  = (state == S_WRITE);
  assign rd_en  = (state == S_READ);

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr} = pin_cmd;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;
  import sdram_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CMD_W-1:0] ini_cmd = NOP_CMD;
  logic             ini_end = 1'b0;
  logic             ref_req = 1'b0;
  logic [CMD_W-1:0] ref_cmd = NOP_CMD;
  logic             ref_end = 1'b0;
  logic             ref_en;
  logic             wr_req = 1'b0;
  logic [CMD_W-1:0] wr_cmd = NOP_CMD;
  logic             wr_end = 1'b0;
  logic             wr_en;
  logic             rd_req = 1'b0;
  logic [CMD_W-1:0] rd_cmd = NOP_CMD;
  logic             rd_end = 1'b0;
  logic             rd_en;
  logic             sdram_cke;
  logic             sdram_cs_n;
  logic             sdram_ras_n;
  logic             sdram_cas_n;
  logic             sdram_we_n;
  logic [1:0]       sdram_ba;
  logic [11:0]      sdram_addr;
  logic             tmo_err;
  logic [CMD_W-1:0] pins;

  int errors = 0;
  int checks = 0;

  localparam logic [CMD_W-1:0] EXP_NOP = 18'h1c000;
  localparam logic [CMD_W-1:0] EXP_REF = 18'h04000;
  localparam logic [CMD_W-1:0] WR_C    = 18'h10055;
  localparam logic [CMD_W-1:0] RD_C    = 18'h14123;

  sdram_arbit dut (
    .clk(clk), .rst_n(rst_n),
    .ini_cmd(ini_cmd), .ini_end(ini_end),
    .ref_req(ref_req), .ref_cmd(ref_cmd), .ref_end(ref_end), .ref_en(ref_en),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_end(wr_end), .wr_en(wr_en),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_end(rd_end), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (pins !== EXP_NOP) begin errors++; $display("FAIL reset_pins: got %h expected %h", pins, EXP_NOP); end
    checks++;
    if ({sdram_cke, ref_en, wr_en, rd_en, tmo_err} !== 5'b0)
      begin errors++; $display("FAIL reset_outs: got %b expected 00000", {sdram_cke, ref_en, wr_en, rd_en, tmo_err}); end
  endtask

  task automatic test_init();
    logic [CMD_W-1:0] exp_cmd;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_cmd = make_cmd(OP_MRS + 4'(i % 3), 2'(i), 12'(i * 37));
      ini_cmd = exp_cmd;
      ini_end = (i == 19);
      tick();
      checks++;
      if (pins !== exp_cmd || sdram_cke !== 1'b1 || {ref_en, wr_en, rd_en} !== 3'b0)
        begin errors++; $display("FAIL init_cycle%0d: got pins=%h cke=%b expected pins=%h cke=1", i, pins, sdram_cke, exp_cmd); end
    end
    ini_end = 1'b0;
    ini_cmd = 18'h3ffff;
    tick();
    checks++;
    if (pins !== EXP_NOP) begin errors++; $display("FAIL init_nop_after: got %h expected %h", pins, EXP_NOP); end
  endtask

  task automatic test_priority();
    int ref_seen = 0;
    ref_req = 1'b1;
    wr_req  = 1'b1;
    wr_cmd  = WR_C;
    tick();
    checks++;
    if (ref_en !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL prio_first: got ref_en=%b wr_en=%b expected 1 0", ref_en, wr_en); end
    ref_req = 1'b0;
    ref_cmd = EXP_REF;
    tick();
    if (pins === EXP_REF) ref_seen++;
    ref_cmd = NOP_CMD;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pins === EXP_REF) ref_seen++;
      checks++;
      if (ref_en !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL prio_hold%0d: got ref_en=%b wr_en=%b expected 1 0", i, ref_en, wr_en); end
    end
    ref_end = 1'b1;
    tick();
    if (pins === EXP_REF) ref_seen++;
    ref_end = 1'b0;
    checks++;
    if (ref_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL prio_gap: got ref_en=%b wr_en=%b expected 0 0", ref_en, wr_en); end
    tick();
    if (pins === EXP_REF) ref_seen++;
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL prio_wr_grant: got %b expected 1", wr_en); end
    wr_req = 1'b0;
    tick();
    checks++;
    if (pins !== WR_C) begin errors++; $display("FAIL prio_wr_pins: got %h expected %h", pins, WR_C); end
    checks++;
    if (ref_seen !== 1) begin errors++; $display("FAIL prio_ref_once: got %0d expected 1", ref_seen); end
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL prio_wr_release: got %b expected 0", wr_en); end
  endtask

  task automatic test_wait_mid_grant();
    rd_cmd = RD_C;
    rd_req = 1'b1;
    tick();
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL wait_rd_grant: got %b expected 1", rd_en); end
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    wr_req = 1'b1;
    wr_end = 1'b1;
    ref_end = 1'b1;
    tick();
    wr_end = 1'b0;
    ref_end = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || pins !== RD_C)
      begin errors++; $display("FAIL wait_foreign_end: got rd_en=%b wr_en=%b pins=%h expected 1 0 %h", rd_en, wr_en, pins, RD_C); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_en !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL wait_hold%0d: got rd_en=%b wr_en=%b expected 1 0", i, rd_en, wr_en); end
    end
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL wait_gap: got rd_en=%b wr_en=%b expected 0 0", rd_en, wr_en); end
    tick();
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL wait_wr_grant: got %b expected 1", wr_en); end
    wr_req = 1'b0;
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 1;
    int early = 0;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    while (wr_en === 1'b1 && n < 2000) begin
      if (tmo_err !== 1'b0) early++;
      tick();
      if (wr_en === 1'b1) n++;
    end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL tmo_grant_len: got %0d expected 1024", n); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL tmo_early_err: got %0d expected 0", early); end
    checks++;
    if (wr_en !== 1'b0 || tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_release: got wr_en=%b tmo_err=%b expected 0 1", wr_en, tmo_err); end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_next_rd: got rd_en=%b tmo_err=%b expected 1 1", rd_en, tmo_err); end
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
  endtask

  task automatic test_rw_tie();
    logic [3:0] got_w = 4'b0;
    logic [3:0] exp_w;
    int k;
`ifdef RW_ROUND_ROBIN_EN
    exp_w = 4'b0101;
`else
    exp_w = 4'b1111;
`endif
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (wr_en !== 1'b1 && rd_en !== 1'b1 && k < 10) begin
        tick();
        k++;
      end
      checks++;
      if (k >= 10) begin errors++; $display("FAIL tie_grant%0d: got no grant expected one within 10 cycles", g); end
      got_w[g] = wr_en;
      wr_end = wr_en;
      rd_end = rd_en;
      tick();
      wr_end = 1'b0;
      rd_end = 1'b0;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    checks++;
    if (got_w !== exp_w) begin errors++; $display("FAIL tie_order: got %b expected %b (bit=1 is write, g0 in bit0)", got_w, exp_w); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    wr_cmd = WR_C;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    tick();
    checks++;
    if (wr_en !== 1'b1 || pins !== WR_C) begin errors++; $display("FAIL rstmid_pre: got wr_en=%b pins=%h expected 1 %h", wr_en, pins, WR_C); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || pins !== EXP_NOP || sdram_cke !== 1'b0 || tmo_err !== 1'b0)
      begin errors++; $display("FAIL rstmid_abort: got wr_en=%b pins=%h cke=%b tmo=%b expected 0 %h 0 0", wr_en, pins, sdram_cke, tmo_err, EXP_NOP); end
    tick();
    rst_n = 1'b1;
    ini_cmd = PRE_CMD;
    wr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (wr_en !== 1'b0 || pins !== PRE_CMD || sdram_cke !== 1'b1)
        begin errors++; $display("FAIL rstmid_init%0d: got wr_en=%b pins=%h cke=%b expected 0 %h 1", i, wr_en, pins, sdram_cke, PRE_CMD); end
    end
    ini_end = 1'b1;
    tick();
    ini_end = 1'b0;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_arbit: got %b expected 0", wr_en); end
    tick();
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: got %b expected 1", wr_en); end
    wr_req = 1'b0;
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_priority();
    test_wait_mid_grant();
    test_timeout();
    test_rw_tie();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
